// File: rtl/sel_cursor_if.sv
// Cursor controller bus bundle.
// Raw buttons and handshake in, cursor state out.
interface sel_cursor_if #(
   parameter int N_POS = 4
);
   logic             btn_left;
   logic             btn_right;
   logic             btn_sel;
   logic             home;
   logic             choice_ack;
   logic [3:0]       pos;
   logic [N_POS-1:0] set_onehot;
   logic [3:0]       choice;
   logic             choice_valid;
   logic             locked;

   modport master (
      output btn_left, btn_right, btn_sel, home, choice_ack,
      input  pos, set_onehot, choice, choice_valid, locked
   );

   modport slave (
      input  btn_left, btn_right, btn_sel, home, choice_ack,
      output pos, set_onehot, choice, choice_valid, locked
   );
endinterface

// File: rtl/sel_cursor_ctrl.sv
// Selection cursor controller: button conditioning,
// saturating cursor, hold-to-repeat, choice handshake.
module sel_cursor_ctrl #(
   parameter int N_POS        = 4,
   parameter int DEB_CYCLES   = 4,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 4,
   parameter int IDLE_TIMEOUT = 64
) (
   input logic         clk,
   input logic         rst_n,
   sel_cursor_if.slave bus
);
   localparam int DW   = $clog2(DEB_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                         REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int IW   = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [3:0] NMAX = 4'(N_POS);

   typedef enum logic [1:0] {
      S_IDLE, S_HOLD, S_REPEAT, S_LOCK
   } state_t;

   // bit 0 left, bit 1 right, bit 2 select
   logic [2:0]    raw, sync1, sync2;
   logic [2:0]    deb, deb_d, armed, press;
   logic [DW-1:0] dcnt [3];

   state_t           state;
   logic             dir;
   logic [RW-1:0]    rcnt;
   logic [IW-1:0]    icnt;
   logic [3:0]       pos, choice;
   logic [N_POS-1:0] onehot;
   logic             valid, locked;

   logic [3:0] pos_l, pos_r, step_pos, press_pos;
   logic       held, both, rep_due;

   function automatic logic [N_POS-1:0] to_onehot(
      input logic [3:0] p
   );
      logic [N_POS-1:0] v;
      v = '0;
      for (int i = 0; i < N_POS; i++)
         v[i] = (p == 4'(i + 1));
      return v;
   endfunction

   assign raw = {bus.btn_sel, bus.btn_right, bus.btn_left};

   // Synchroniser stays unreset so a button held through reset
   // is still seen as held and cannot fake a fresh press.
   always_ff @(posedge clk) begin
      sync1 <= raw;
      sync2 <= sync1;
   end

   // Debounce each button; arm edge detection once seen released.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deb   <= '0;
         deb_d <= '0;
         armed <= '0;
         for (int i = 0; i < 3; i++)
            dcnt[i] <= '0;
      end else begin
         deb_d <= deb;
         for (int i = 0; i < 3; i++) begin
            if (!sync2[i] && !deb[i])
               armed[i] <= 1'b1;
            if (sync2[i] == deb[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DW'(DEB_CYCLES)) begin
               deb[i]  <= ~deb[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end
         end
      end
   end

   assign press     = deb & ~deb_d & armed;
   assign both      = deb[0] & deb[1];
   assign held      = dir ? deb[1] : deb[0];
   assign pos_l     = (pos <= 4'd1) ? 4'd1 : pos - 4'd1;
   assign pos_r     = (pos >= NMAX) ? NMAX : pos + 4'd1;
   assign step_pos  = dir ? pos_r : pos_l;
   assign press_pos = press[1] ? pos_r : pos_l;
   assign rep_due   =
      (state == S_HOLD   && rcnt == RW'(REPEAT_DELAY - 1)) ||
      (state == S_REPEAT && rcnt == RW'(REPEAT_RATE - 1));

   // Cursor state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         dir    <= 1'b0;
         rcnt   <= '0;
         icnt   <= '0;
         pos    <= 4'd1;
         onehot <= to_onehot(4'd1);
         choice <= '0;
         valid  <= 1'b0;
         locked <= 1'b0;
      end else if (bus.home) begin
         state  <= S_IDLE;
         rcnt   <= '0;
         icnt   <= '0;
         pos    <= 4'd1;
         onehot <= to_onehot(4'd1);
         choice <= '0;
         valid  <= 1'b0;
         locked <= 1'b0;
      end else if (state == S_LOCK) begin
         rcnt <= '0;
         icnt <= '0;
         if (bus.choice_ack) begin
            state  <= S_IDLE;
            choice <= '0;
            valid  <= 1'b0;
            locked <= 1'b0;
         end
      end else if (press[2]) begin
         state  <= S_LOCK;
         rcnt   <= '0;
         icnt   <= '0;
         choice <= pos;
         valid  <= 1'b1;
         locked <= 1'b1;
      end else if (both) begin
         state <= S_IDLE;
         rcnt  <= '0;
         icnt  <= '0;
      end else if (press[0] || press[1]) begin
         state  <= S_HOLD;
         dir    <= press[1];
         rcnt   <= '0;
         icnt   <= '0;
         pos    <= press_pos;
         onehot <= to_onehot(press_pos);
      end else begin
         unique case (state)
            S_IDLE: begin
               if (|deb) begin
                  icnt <= '0;
               end else if (icnt == IW'(IDLE_TIMEOUT - 1)) begin
                  icnt   <= '0;
                  pos    <= 4'd1;
                  onehot <= to_onehot(4'd1);
               end else begin
                  icnt <= icnt + 1'b1;
               end
            end
            S_HOLD, S_REPEAT: begin
               icnt <= '0;
               if (!held) begin
                  state <= S_IDLE;
                  rcnt  <= '0;
               end else if (rep_due) begin
                  state  <= S_REPEAT;
                  rcnt   <= '0;
                  pos    <= step_pos;
                  onehot <= to_onehot(step_pos);
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.pos          = pos;
   assign bus.set_onehot   = onehot;
   assign bus.choice       = choice;
   assign bus.choice_valid = valid;
   assign bus.locked       = locked;
endmodule

// File: tb/tb_sel_cursor_ctrl.sv
// Directed bench for sel_cursor_ctrl with default parameters.
// Inputs change 1 time unit after a rising edge.
module tb_sel_cursor_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sel_cursor_if #(.N_POS(4)) bus ();

   sel_cursor_ctrl #(
      .N_POS(4), .DEB_CYCLES(4), .REPEAT_DELAY(8),
      .REPEAT_RATE(4), .IDLE_TIMEOUT(64)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: bus.btn_left  = v;
         1: bus.btn_right = v;
         default: bus.btn_sel = v;
      endcase
   endtask

   // raw high for 7 edges: enough for one debounced press
   task automatic tap(input int b, input logic [3:0] exp,
                      input string tag);
      set_btn(b, 1'b1);
      cyc(7);
      set_btn(b, 1'b0);
      cyc(1);
      chk(tag, bus.pos, exp);
      cyc(12);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.btn_left   = 1'b0;
      bus.btn_right  = 1'b0;
      bus.btn_sel    = 1'b0;
      bus.home       = 1'b0;
      bus.choice_ack = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      chk("rst_pos", bus.pos, 4'd1);
      chk("rst_onehot", bus.set_onehot, 4'b0001);
      chk("rst_choice", bus.choice, 4'd0);
      chk("rst_valid", bus.choice_valid, 1'b0);
      chk("rst_locked", bus.locked, 1'b0);

      // first press: step lands on edge E+7
      bus.btn_right = 1'b1;
      cyc(7);
      chk("r1_early", bus.pos, 4'd1);
      bus.btn_right = 1'b0;
      cyc(1);
      chk("r1_pos", bus.pos, 4'd2);
      chk("r1_onehot", bus.set_onehot, 4'b0010);
      cyc(12);
      tap(1, 4'd3, "r2_pos");
      tap(1, 4'd4, "r3_pos");
      tap(1, 4'd4, "r4_sat");
      tap(1, 4'd4, "r5_sat");
      tap(1, 4'd4, "r6_sat");
      chk("rsat_onehot", bus.set_onehot, 4'b1000);

      // left held: press step, +8, +12, then floor
      bus.btn_left = 1'b1;
      cyc(7);
      chk("lh_early", bus.pos, 4'd4);
      cyc(1);
      chk("lh_press", bus.pos, 4'd3);
      cyc(7);
      chk("lh_p7", bus.pos, 4'd3);
      cyc(1);
      chk("lh_p8", bus.pos, 4'd2);
      cyc(3);
      chk("lh_p11", bus.pos, 4'd2);
      cyc(1);
      chk("lh_p12", bus.pos, 4'd1);
      chk("lh_onehot", bus.set_onehot, 4'b0001);
      cyc(20);
      chk("lh_floor", bus.pos, 4'd1);
      bus.btn_left = 1'b0;
      cyc(12);

      // short glitch is filtered
      tap(1, 4'd2, "g_setup1");
      tap(1, 4'd3, "g_setup2");
      bus.btn_left = 1'b1;
      cyc(3);
      bus.btn_left = 1'b0;
      cyc(12);
      chk("glitch_pos", bus.pos, 4'd3);

      // select locks the choice
      bus.btn_sel = 1'b1;
      cyc(7);
      chk("sel_early", bus.choice_valid, 1'b0);
      bus.btn_sel = 1'b0;
      cyc(1);
      chk("sel_choice", bus.choice, 4'd3);
      chk("sel_valid", bus.choice_valid, 1'b1);
      chk("sel_locked", bus.locked, 1'b1);
      cyc(12);
      tap(1, 4'd3, "lock_right");
      tap(2, 4'd3, "lock_sel");
      chk("lock_choice", bus.choice, 4'd3);
      cyc(70);
      chk("lock_noidle", bus.pos, 4'd3);
      chk("lock_valid", bus.choice_valid, 1'b1);

      // ack releases on the edge that samples it
      bus.choice_ack = 1'b1;
      cyc(1);
      bus.choice_ack = 1'b0;
      chk("ack_valid", bus.choice_valid, 1'b0);
      chk("ack_choice", bus.choice, 4'd0);
      chk("ack_locked", bus.locked, 1'b0);
      chk("ack_pos", bus.pos, 4'd3);

      // idle timeout 64 cycles after unlock
      cyc(63);
      chk("idle_63", bus.pos, 4'd3);
      chk("idle_noqueue", bus.choice_valid, 1'b0);
      cyc(1);
      chk("idle_64", bus.pos, 4'd1);
      chk("idle_onehot", bus.set_onehot, 4'b0001);

      // home while locked
      tap(1, 4'd2, "h_setup1");
      tap(1, 4'd3, "h_setup2");
      tap(2, 4'd3, "h_sel");
      chk("h_locked", bus.locked, 1'b1);
      bus.home = 1'b1;
      cyc(1);
      bus.home = 1'b0;
      chk("home_pos", bus.pos, 4'd1);
      chk("home_valid", bus.choice_valid, 1'b0);
      chk("home_choice", bus.choice, 4'd0);
      chk("home_locked", bus.locked, 1'b0);
      tap(1, 4'd2, "home_idle");

      // reset during repeat at pos 2
      tap(1, 4'd3, "rr_setup1");
      tap(1, 4'd4, "rr_setup2");
      bus.btn_left = 1'b1;
      cyc(8);
      chk("rr_press", bus.pos, 4'd3);
      cyc(8);
      chk("rr_rep", bus.pos, 4'd2);
      cyc(1);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      chk("rr_pos", bus.pos, 4'd1);
      chk("rr_onehot", bus.set_onehot, 4'b0001);
      chk("rr_valid", bus.choice_valid, 1'b0);
      chk("rr_locked", bus.locked, 1'b0);
      cyc(30);
      chk("rr_held", bus.pos, 4'd1);
      bus.btn_left = 1'b0;
      cyc(12);

      // right held through reset must not step
      bus.btn_right = 1'b1;
      cyc(8);
      chk("rh_press", bus.pos, 4'd2);
      cyc(2);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      chk("rh_pos", bus.pos, 4'd1);
      cyc(30);
      chk("rh_held", bus.pos, 4'd1);
      bus.btn_right = 1'b0;
      cyc(12);
      tap(1, 4'd2, "rh_repress");
      tap(0, 4'd1, "rh_left");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
